branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/bpu_pkg.sv | 26 ++
 rtl/bpu_table.sv | 35 +++
 rtl/branch_predict_unit.sv | 146 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit: control-transfer
// encodings, the halt redirect address and the BTB/BHT entry layout.
package bpu_pkg;

    typedef enum logic [1:0] {
        NO_CTRL = 2'b00,
        JAL     = 2'b01,
        JALR    = 2'b10,
        BRANCH  = 2'b11
    } ctrl_e;

    localparam logic [31:0] HALT_PC = 32'hFFFF_FFFF;

    // Fields are sized for the widest supported configuration; narrower
    // configurations store zero-extended values and the upper bits fold away.
    localparam int TAG_MAX_W = 32;
    localparam int CNT_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [CNT_MAX_W-1:0] counter;
    } btb_entry_t;

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped BTB/BHT storage: combinational lookups, one synchronous
// write port with an invalidate, all entries cleared by reset.
module bpu_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // lookup lane 0 serves fetch, lane 1 the resolve-stage hit check
    input  logic [1:0][IDX_W-1:0] rd_idx_i,
    output btb_entry_t [1:0]      rd_entry_o,
    input  logic                  wr_en_i,
    input  logic                  inv_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  btb_entry_t            wr_entry_i
);

    btb_entry_t [ENTRIES-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end else if (inv_en_i) begin
            mem_q[wr_idx_i].valid <= 1'b0;
        end
    end

    assign rd_entry_o[0] = mem_q[rd_idx_i[0]];
    assign rd_entry_o[1] = mem_q[rd_idx_i[1]];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: BTB lookup at fetch, outcome/mispredict resolution at EX,
// counter training, sticky halt and performance counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic [1:0]      res_ctrl,
    input  logic [31:0]     res_imm,
    input  logic [31:0]     res_alu,
    input  logic            res_pred_taken,
    input  logic [31:0]     res_pred_target,
    input  logic            halt,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            halted,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_MAX_W-1:0] CNT_MAX  = CNT_MAX_W'((1 << CNT_W) - 1);
    localparam logic [CNT_MAX_W-1:0] CNT_WEAK = CNT_MAX_W'(1 << (CNT_W - 1));

    if (PC_W <= IDX_W + 2) begin : g_bad_pc_w
        $error("branch_predict_unit: PC_W must exceed log2(ENTRIES)+2");
    end
    if (ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("branch_predict_unit: ENTRIES must be a power of two >= 2");
    end
    if (CNT_W < 1 || CNT_W > CNT_MAX_W || TAG_W > TAG_MAX_W) begin : g_bad_cnt_w
        $error("branch_predict_unit: CNT_W/TAG width out of range");
    end

    logic [1:0][IDX_W-1:0] rd_idx;
    btb_entry_t [1:0]      rd_entry;
    btb_entry_t            fe, re, wr_entry;
    logic                  wr_en, inv_en;
    logic                  halted_q;
    logic [31:0]           branch_cnt_q, mispred_cnt_q;
    logic                  unused_pc_lsb;

    assign rd_idx[0] = fetch_pc[IDX_W+1:2];
    assign rd_idx[1] = res_pc[IDX_W+1:2];
    assign fe = rd_entry[0];
    assign re = rd_entry[1];
    assign unused_pc_lsb = ^fetch_pc[1:0];

    bpu_table #(.ENTRIES(ENTRIES)) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (rd_idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (wr_en),
        .inv_en_i   (inv_en),
        .wr_idx_i   (rd_idx[1]),
        .wr_entry_i (wr_entry)
    );

    assign pred_taken  = fe.valid && (fe.tag == TAG_MAX_W'(fetch_pc[PC_W-1:IDX_W+2]))
                         && (fe.counter >= CNT_WEAK);
    assign pred_target = fe.target;

    logic        act, upd, hit, act_taken, mispred;
    logic [31:0] pc32, act_tgt;
    ctrl_e       ctrl;

    assign ctrl = ctrl_e'(res_ctrl);
    assign pc32 = 32'(res_pc);
    assign act  = res_valid && !halted_q;
    assign upd  = act && !halt;
    assign hit  = re.valid && (re.tag == TAG_MAX_W'(res_pc[PC_W-1:IDX_W+2]));

    always_comb begin
        act_taken = 1'b0;
        act_tgt   = pc32 + res_imm;
        case (ctrl)
            JAL:     act_taken = 1'b1;
            JALR: begin
                act_taken = 1'b1;
                act_tgt   = (pc32 + res_alu) & 32'hFFFF_FFFE;
            end
            BRANCH:  act_taken = res_alu[0];
            default: act_taken = 1'b0;
        endcase
    end

    assign mispred = act && ((act_taken != res_pred_taken) ||
                             (act_taken && res_pred_taken && act_tgt != res_pred_target));

    // Halt (pending or sticky) overrides any mispredict redirect.
    assign redirect    = halted_q || (act && halt) || mispred;
    assign redirect_pc = (halted_q || (act && halt)) ? HALT_PC :
                         act_taken ? act_tgt : pc32 + 32'd4;

    always_comb begin
        wr_en    = 1'b0;
        inv_en   = 1'b0;
        wr_entry = '{valid: 1'b1, tag: TAG_MAX_W'(res_pc[PC_W-1:IDX_W+2]),
                     target: act_tgt, counter: CNT_MAX};
        case (ctrl)
            JAL, JALR: wr_en = upd;
            BRANCH: begin
                if (act_taken) begin
                    wr_en = upd;
                    wr_entry.counter = !hit ? CNT_WEAK :
                                       (re.counter == CNT_MAX) ? CNT_MAX : re.counter + 1'b1;
                end else if (hit) begin
                    wr_en = upd;
                    wr_entry.target  = re.target;
                    wr_entry.counter = (re.counter == '0) ? '0 : re.counter - 1'b1;
                end
            end
            default: inv_en = upd && hit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q      <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (act && halt) halted_q <= 1'b1;
            if (upd && ctrl != NO_CTRL && branch_cnt_q != 32'hFFFF_FFFF)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (upd && mispred && mispred_cnt_q != 32'hFFFF_FFFF)
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign halted      = halted_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;
    import bpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [8:0]  res_pc;
    logic [1:0]  res_ctrl;
    logic [31:0] res_imm, res_alu;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] branch_cnt, mispred_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    branch_predict_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_ctrl        (res_ctrl),
        .res_imm         (res_imm),
        .res_alu         (res_alu),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .halt            (halt),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halted          (halted),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [1:0] c, input logic [8:0] pc, input logic [31:0] imm,
                           input logic [31:0] alu, input logic pt, input logic [31:0] ptgt);
        res_valid = 1'b1; res_ctrl = c; res_pc = pc; res_imm = imm; res_alu = alu;
        res_pred_taken = pt; res_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0; res_ctrl = 2'b00; halt = 1'b0;
        #1;
    endtask

    task automatic look(input logic [8:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_pc = '0; halt = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_ctrl = 2'b00; res_imm = '0; res_alu = '0;
        res_pred_taken = 1'b0; res_pred_target = '0;
        #12;
        chk("rst_pred_taken", 32'(pred_taken), 0);
        chk("rst_pred_target", pred_target, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_mispred_cnt", mispred_cnt, 0);
        rst_n = 1'b1;
        step();

        // Taken branch on a cold entry allocates weak-taken; no same-cycle bypass.
        look(9'h040);
        chk("cold_lookup", 32'(pred_taken), 0);
        resolve(2'b11, 9'h040, 32'h20, 32'h1, 1'b0, 32'h0);
        chk("br_redirect", 32'(redirect), 1);
        chk("br_redirect_pc", redirect_pc, 32'h60);
        chk("br_no_bypass", 32'(pred_taken), 0);
        step(); idle();
        chk("br_alloc_taken", 32'(pred_taken), 1);
        chk("br_alloc_target", pred_target, 32'h60);
        chk("br_mispred_cnt", mispred_cnt, 1);

        // Two not-taken resolves: 10 -> 01 -> 00.
        resolve(2'b11, 9'h040, 32'h20, 32'h0, 1'b1, 32'h60);
        chk("nt1_redirect_pc", redirect_pc, 32'h44);
        step(); idle();
        chk("nt1_pred", 32'(pred_taken), 0);
        chk("nt1_mispred_cnt", mispred_cnt, 2);
        resolve(2'b11, 9'h040, 32'h20, 32'h0, 1'b0, 32'h0);
        chk("nt2_redirect", 32'(redirect), 0);
        step(); idle();
        chk("nt2_mispred_cnt", mispred_cnt, 2);
        chk("nt2_branch_cnt", branch_cnt, 3);
        // Counter at 00: one taken hit only reaches 01, still predicting not-taken.
        resolve(2'b11, 9'h040, 32'h20, 32'h1, 1'b0, 32'h0);
        step(); idle();
        chk("sat0_pred", 32'(pred_taken), 0);

        // JALR target alignment, mispredicted target.
        resolve(2'b10, 9'h010, 32'h0, 32'h33, 1'b1, 32'h40);
        chk("jalr_redirect", 32'(redirect), 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h42);
        step(); idle();
        look(9'h010);
        chk("jalr_pred", 32'(pred_taken), 1);
        chk("jalr_target", pred_target, 32'h42);
        chk("jalr_mispred_cnt", mispred_cnt, 4);

        // Same index, different tag: 0x044 evicts 0x004.
        resolve(2'b01, 9'h004, 32'h100, 32'h0, 1'b0, 32'h0);
        step(); idle();
        look(9'h004);
        chk("jal4_target", pred_target, 32'h104);
        resolve(2'b01, 9'h044, 32'h8, 32'h0, 1'b0, 32'h0);
        step(); idle();
        look(9'h044);
        chk("jal44_pred", 32'(pred_taken), 1);
        chk("jal44_target", pred_target, 32'h4C);
        look(9'h004);
        chk("evicted_miss", 32'(pred_taken), 0);

        // Correct prediction: no redirect, branch count only.
        resolve(2'b01, 9'h044, 32'h8, 32'h0, 1'b1, 32'h4C);
        chk("good_pred_redirect", 32'(redirect), 0);
        step(); idle();
        chk("good_branch_cnt", branch_cnt, 8);
        chk("good_mispred_cnt", mispred_cnt, 6);

        // NO_CTRL invalidates a hit; predicted-taken NO_CTRL redirects to pc+4.
        resolve(2'b00, 9'h044, 32'h0, 32'h0, 1'b0, 32'h0);
        step(); idle();
        look(9'h044);
        chk("noctrl_inval", 32'(pred_taken), 0);
        resolve(2'b00, 9'h010, 32'h0, 32'h0, 1'b1, 32'h42);
        chk("noctrl_redirect_pc", redirect_pc, 32'h14);
        step(); idle();
        look(9'h010);
        chk("noctrl_inval2", 32'(pred_taken), 0);
        chk("noctrl_branch_cnt", branch_cnt, 8);
        chk("noctrl_mispred_cnt", mispred_cnt, 7);

        // 32-bit wrap of the target.
        resolve(2'b01, 9'h1FC, 32'hFFFF_FE04, 32'h0, 1'b0, 32'h0);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        step(); idle();
        look(9'h1FC);
        chk("wrap_pred", 32'(pred_taken), 1);

        // Halt: immediate redirect, sticky, everything frozen.
        halt = 1'b1;
        resolve(2'b00, 9'h020, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("halt_redirect_pc", redirect_pc, 32'hFFFF_FFFF);
        chk("halt_not_yet", 32'(halted), 0);
        step(); idle();
        chk("halted", 32'(halted), 1);
        chk("halted_redirect", 32'(redirect), 1);
        resolve(2'b11, 9'h080, 32'h10, 32'h1, 1'b0, 32'h0);
        chk("halted_redirect_pc", redirect_pc, 32'hFFFF_FFFF);
        step(); idle();
        look(9'h080);
        chk("halted_no_alloc", 32'(pred_taken), 0);
        chk("halted_branch_cnt", branch_cnt, 9);
        chk("halted_mispred_cnt", mispred_cnt, 8);

        // Reset clears everything asynchronously.
        #2; rst_n = 1'b0; #1;
        look(9'h1FC);
        chk("rst2_pred", 32'(pred_taken), 0);
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_branch_cnt", branch_cnt, 0);
        rst_n = 1'b1;
        step();

        // Pending update dropped by a reset that covers the edge.
        resolve(2'b01, 9'h030, 32'h40, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        step(); idle();
        rst_n = 1'b1;
        step();
        look(9'h030);
        chk("rst_drop_update", 32'(pred_taken), 0);
        chk("rst_drop_cnt", branch_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
